// File: rtl/safecrack_pkg.sv
// Shared types and defaults for the safecrack lockout controller.
// Imported by the controller and its tick generator.
package safecrack_pkg;

  typedef enum logic [1:0] {
    ARMED        = 2'd0,
    LOCKED       = 2'd1,
    RELEASE_WAIT = 2'd2
  } lock_state_t;

  localparam logic [3:0] BTN_NONE = 4'b1111;

  localparam int DEFAULT_LOCK_SECONDS = 10;
  localparam int DEFAULT_MAX_ERRORS   = 3;

endpackage

// File: rtl/safecrack_tick_gen.sv
// One-cycle tick every TICKS_PER_SEC enabled cycles.
// The count restarts from zero whenever en drops.
module safecrack_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(TICKS_PER_SEC);
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/safecrack_lockout_ctrl.sv
// Press-edge detection, failed-attempt counting and timed lockout
// in front of the safecrack passcode FSM.
module safecrack_lockout_ctrl
  import safecrack_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int LOCK_SECONDS  = DEFAULT_LOCK_SECONDS,
  parameter int MAX_ERRORS    = DEFAULT_MAX_ERRORS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              btn,
  input  logic                    attempt_fail,
  input  logic                    attempt_pass,
  output logic                    press_valid,
  output logic [3:0]              press_code,
  output logic                    locked_out,
  output logic [2:0]              leds_erros,
  output logic [LOCK_SECONDS-1:0] leds_segundos
);

  localparam logic [1:0] ERR_LAST = 2'(MAX_ERRORS - 1);
  localparam logic [1:0] ERR_MAX  = 2'(MAX_ERRORS);
  localparam logic [3:0] SEC_LAST = 4'(LOCK_SECONDS - 1);

  lock_state_t state_q, state_d;
  logic [1:0]  err_q, err_d;
  logic [3:0]  sec_q, sec_d;
  logic [3:0]  btn_q;
  logic        pv_q, pv_d;
  logic [3:0]  code_q, code_d;
  logic        tick;
  logic        press_ev;

  assign press_ev = (btn != BTN_NONE) && (btn_q == BTN_NONE);

  safecrack_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q == LOCKED),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    sec_d   = sec_q;
    pv_d    = 1'b0;
    code_d  = code_q;
    case (state_q)
      ARMED: begin
        if (press_ev) begin
          pv_d   = 1'b1;
          code_d = btn;
        end
        // fail has priority over a coincident pass
        if (attempt_fail) begin
          if (err_q >= ERR_LAST) begin
            err_d   = ERR_MAX;
            sec_d   = '0;
            state_d = LOCKED;
          end else begin
            err_d = err_q + 1'b1;
          end
        end else if (attempt_pass) begin
          err_d = '0;
        end
      end
      LOCKED: begin
        if (tick) begin
          if (sec_q == SEC_LAST) begin
            err_d   = '0;
            sec_d   = '0;
            state_d = (btn != BTN_NONE) ? RELEASE_WAIT : ARMED;
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (btn == BTN_NONE) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMED;
      err_q   <= '0;
      sec_q   <= '0;
      btn_q   <= BTN_NONE;
      pv_q    <= 1'b0;
      code_q  <= BTN_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      sec_q   <= sec_d;
      btn_q   <= btn;
      pv_q    <= pv_d;
      code_q  <= code_d;
    end
  end

  assign press_valid = pv_q;
  assign press_code  = code_q;
  assign locked_out  = (state_q == LOCKED);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      leds_erros[i] = (err_q > 2'(i));
    end
    for (int i = 0; i < LOCK_SECONDS; i++) begin
      leds_segundos[i] = locked_out && (sec_q >= 4'(i));
    end
  end

endmodule
